// File: rtl/fpu_pkg.sv
// Shared types for the FP compare issuer: compare ops, FSM states and the queued request.
package fpu_pkg;

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LE = 3'd2,
    CMP_GE = 3'd3,
    CMP_LT = 3'd4,
    CMP_GT = 3'd5
  } cmp_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } issuer_state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
  } cmp_req_t;

  // Encodings 6 and 7 have no compare meaning and are rejected without issue.
  function automatic logic is_legal_cmp_op(input logic [2:0] op);
    return (op <= 3'(CMP_GT));
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// First-word-fall-through request queue; the head is read in place and also the
// entry behind it, so the issuer can decide its next state while popping.
module fpu_req_fifo #(
  parameter int  DEPTH  = 2,
  parameter type elem_t = logic [7:0]
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   push,
  input  elem_t                  wdata,
  input  logic                   pop,
  output elem_t                  head,
  output elem_t                  peek,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  elem_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic          wr_en;
  logic          rd_en;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign wr_en      = push && !full;
  assign rd_en      = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + PW'(1);
  assign head       = mem[rd_ptr];
  assign peek       = mem[rd_ptr_nxt];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr_nxt;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_cmp_issuer.sv
// Queues FP compare requests, issues them one at a time to the compare unit and
// returns a single-cycle writeback; illegal ops and a hung unit report an error.
module fpu_cmp_issuer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_rd,
  output logic        data_valid,
  output logic [31:0] a_data,
  output logic [31:0] b_data,
  output logic [2:0]  op_data,
  input  logic [31:0] c_data,
  input  logic        c_valid,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic        err_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  issuer_state_t state;
  cmp_req_t      wdata;
  cmp_req_t      head;
  cmp_req_t      peek;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          has_next;
  logic [2:0]    next_op;
  logic [TW-1:0] tmo_cnt;
  logic          result;
  logic          err_flag;
  logic          halt_armed;
  logic          unused_bits;

  // Request handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready depends only on registered state, never
  // on req_valid, and the core may drop req_valid at will before transfer.
  assign req_ready = !full && (state != ST_HALT);
  assign push      = req_valid && req_ready;
  assign pop       = (state == ST_WB);
  assign wdata     = {req_a, req_b, req_op, req_rd};

  fpu_req_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (cmp_req_t)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop),
    .head    (head),
    .peek    (peek),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // After the WB pop the new head is either the entry already queued behind it
  // or, with only one entry queued, whatever is being pushed this cycle.
  assign has_next = (count > CW'(1)) || push;
  assign next_op  = (count > CW'(1)) ? peek.op : req_op;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      result     <= 1'b0;
      err_flag   <= 1'b0;
      halt_armed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (is_legal_cmp_op(head.op)) begin
              state <= ST_ISSUE;
            end else begin
              state    <= ST_WB;
              result   <= 1'b0;
              err_flag <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (c_valid) begin
            result   <= c_data[0];
            err_flag <= 1'b0;
            state    <= ST_WB;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            result     <= 1'b0;
            err_flag   <= 1'b1;
            halt_armed <= 1'b1;
            state      <= ST_WB;
          end
        end
        ST_WB: begin
          if (halt_armed) begin
            state <= ST_HALT;
          end else if (has_next) begin
            if (is_legal_cmp_op(next_op)) begin
              state <= ST_ISSUE;
            end else begin
              state    <= ST_WB;
              result   <= 1'b0;
              err_flag <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operands come straight from the queue head, which stays put until the WB pop.
  assign a_data     = head.a;
  assign b_data     = head.b;
  assign op_data    = head.op;
  assign data_valid = (state == ST_ISSUE);
  assign wb_valid   = (state == ST_WB);
  assign wb_rd      = (state == ST_WB) ? head.rd : 5'd0;
  assign wb_data    = {31'b0, (state == ST_WB) && result};
  assign wb_err     = (state == ST_WB) && err_flag;
  assign err_o      = (state == ST_HALT);

  assign unused_bits = ^{c_data[31:1], peek.a, peek.b, peek.rd};

endmodule
